ula_arbiter: RTL
================

# ula_arbiter

Shares one combinational 8-bit ULA datapath between two independent requesters. Each requester submits (a, b, opcode) over a valid/ready handshake. The block grants requesters round-robin, registers the operands into the single ULA instance, captures s/flag, and returns them on that requester's response channel. It sits between the ULA and any two masters, such as a CPU execute stage and a DMA checksum engine.

## Interface
- WIDTH, 8, operand/result width; must equal the ULA data width.
- clk  in  1  rising-edge clock; also drives the ULA clk port.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  requester has an operation pending.
- req0_ready / req1_ready  out  1  operation accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands.
- req0_op / req1_op  in  3  ULA opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 nand, 110 xnor, 111 compare.
- rsp0_valid / rsp1_valid  out  1  result available for that requester.
- rsp0_ready / rsp1_ready  in  1  requester consumes the result.
- rsp0_s / rsp1_s  out  WIDTH  captured ULA result.
- rsp0_flag / rsp1_flag  out  1  captured ULA flag.
- busy  out  1  high whenever the state is not IDLE.
- ops_done  out  16  count of completed responses.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - Winner selection: if only one req valid, that requester wins. If both are valid, the requester other than last_grant wins.
  - reqN_ready is driven high combinationally for the winner only. The loser's ready stays 0.
  - On valid&ready, the block latches a, b, op into op_a/op_b/op_code, latches grant_id, sets last_grant=grant_id, and moves to EXEC.
- EXEC:
  - The registered op_a/op_b/op_code drive the ULA.
  - At the clock edge, s and flag are captured into res_s/res_flag, and the FSM moves to RESP.
- RESP:
  - rsp[grant_id]_valid=1, carrying res_s/res_flag. The other requester's rsp_valid stays 0.
  - On rsp[grant_id]_ready=1, ops_done increments and the FSM returns to IDLE.
- No reqN_ready is asserted outside IDLE. Opcodes pass to the ULA unmodified. Arithmetic and flag semantics are entirely the ULA's.
- ops_done wraps from 16'hFFFF to 0.
- Protocol rules, enforced by bench assertions:
  - reqN a/b/op stay stable while valid && !ready.
  - reqN_valid does not drop before ready.
  - rsp data is stable while valid && !ready.

## Timing
- Reset values:
  - Outputs: all reqN_ready=0, rspN_valid=0, rspN_s=0, rspN_flag=0, busy=0, ops_done=0.
  - Internal: last_grant=1, so requester 0 wins the first tie. op_a/op_b/op_code/res_s/res_flag/grant_id = 0.
- Latency: accept in cycle c (valid&ready at the edge ending c). rsp_valid is high in cycle c+2.
- Minimum period is 3 cycles per operation, when the requester holds rsp_ready=1.
- Response backpressure: RESP holds indefinitely. During this time the other requester is blocked, and its valid stays pending.
- Simultaneous events:
  - A rsp_ready edge that returns the FSM to IDLE cannot accept a new request in that same cycle. The next accept is the following IDLE cycle.
- Reset mid-operation: the in-flight op is dropped with no response emitted, and the FSM returns to IDLE immediately (asynchronous).
- busy rises the cycle after accept and falls the cycle after the response handshake.

## Structure
- Package ula_pkg:
  - Opcode localparams OP_ADD..OP_CMP.
  - State enum values IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
  - WIDTH default.
- One sub-module instance: the existing ULA, connected positionally as (a, b, opcode, s, flag, clk) to op_a, op_b, op_code, ula_s, ula_flag, clk.
- The round-robin pick is a small function in the arbiter body, not a separate module.

## Test plan
1. Reset mid-EXEC: req0 add 10+10 accepted, then rst_n pulsed low in the EXEC cycle -> no rsp0_valid ever. All outputs are 0 during reset. busy=0 one cycle later.
2. Single requester: req0 add a=10, b=10 -> req0_ready in the accept cycle. rsp0_valid two cycles later with rsp0_s=20. rsp1_valid stays 0. ops_done=1.
3. Tie after reset: both valid; req0 sub 25-5, req1 and 1&1 -> req0 granted first (rsp0_s=20), then req1 (rsp1_s=1). Next tie goes to req0 again, alternating.
4. Backpressure: req1 xor 1^1 with rsp1_ready held 0 for 5 cycles -> rsp1_valid and rsp1_s=0 stable throughout. req0 pending the whole time with req0_ready=0. req0 is accepted the first IDLE cycle after the handshake.
5. Back-to-back: req0 streams 4 ops (or 2|0, nand 1,0, xnor 1,1, cmp 2,0) with rsp0_ready=1 -> responses arrive exactly 3 cycles apart, in order, with s matching a ULA reference model.
6. Counter wrap: ops_done preloaded via force to 16'hFFFF, then one completed op -> ops_done=0.

Source files
------------

// File: rtl/ula_pkg.sv
// ula_pkg: shared data width, ULA opcodes and arbiter FSM states
package ula_pkg;
  localparam int ULA_WIDTH = 8;
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_CMP  = 3'd7;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/ula.sv
// ula: combinational ALU; a/b/opcode in, s/flag out (carry, borrow, zero, or a==b with s=a<b for compare); clk is unused
module ula
  import ula_pkg::*;
#(
  parameter int WIDTH = ULA_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] s,
  output logic             flag,
  input  logic             clk
);
  logic [WIDTH:0] sum, dif;
  logic unused_clk;
  assign unused_clk = clk;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  always_comb begin
    s = '0;
    flag = 1'b0;
    case (opcode)
      OP_ADD:  {flag, s} = sum;
      OP_SUB:  {flag, s} = dif;
      OP_AND:  s = a & b;
      OP_OR:   s = a | b;
      OP_XOR:  s = a ^ b;
      OP_NAND: s = ~(a & b);
      OP_XNOR: s = ~(a ^ b);
      default: {flag, s} = {a == b, {(WIDTH-1){1'b0}}, a < b};
    endcase
    if (opcode >= OP_AND && opcode <= OP_XNOR) flag = ~|s;
  end
endmodule

// File: rtl/ula_arbiter.sv
// ula_arbiter: round-robin share of one ULA between two valid/ready requesters (req*/rsp* channels, busy, ops_done count)
module ula_arbiter
  import ula_pkg::*;
#(
  parameter int WIDTH = ULA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_s,
  output logic             rsp0_flag,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_s,
  output logic             rsp1_flag,
  output logic             busy,
  output logic [15:0]      ops_done
);
  state_t state;
  logic last_grant, grant_id, win, res_flag, ula_flag;
  logic [WIDTH-1:0] op_a, op_b, res_s, ula_s;
  logic [2:0] op_code;
  function automatic logic pick(input logic v0, input logic v1, input logic last);
    return (v0 && v1) ? !last : v1;
  endfunction
  assign win = pick(req0_valid, req1_valid, last_grant);
  assign req0_ready = state == IDLE && req0_valid && !win;
  assign req1_ready = state == IDLE && req1_valid && win;
  assign rsp0_valid = state == RESP && !grant_id;
  assign rsp1_valid = state == RESP && grant_id;
  assign rsp0_s = res_s;
  assign rsp1_s = res_s;
  assign rsp0_flag = res_flag;
  assign rsp1_flag = res_flag;
  assign busy = state != IDLE;
  ula #(.WIDTH(WIDTH)) u_ula (op_a, op_b, op_code, ula_s, ula_flag, clk);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= 1'b1;
      grant_id <= 1'b0;
      op_a <= '0;
      op_b <= '0;
      op_code <= '0;
      res_s <= '0;
      res_flag <= 1'b0;
      ops_done <= '0;
    end else begin
      case (state)
        IDLE: if (req0_ready || req1_ready) begin
          op_a <= win ? req1_a : req0_a;
          op_b <= win ? req1_b : req0_b;
          op_code <= win ? req1_op : req0_op;
          grant_id <= win;
          last_grant <= win;
          state <= EXEC;
        end
        EXEC: begin
          res_s <= ula_s;
          res_flag <= ula_flag;
          state <= RESP;
        end
        RESP: if (grant_id ? rsp1_ready : rsp0_ready) begin
          ops_done <= ops_done + 16'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
